// File: rtl/tlul_pkg.sv
// TL-UL opcode encodings and the size helper shared by the master arbiter slice.
// Arbitration policy is chosen in tlul_rr_arbiter via TLUL_ARB_FIXED_PRIO_EN.
package tlul_pkg;

  typedef enum logic [2:0] {
    TL_PUT_FULL    = 3'd0,
    TL_PUT_PARTIAL = 3'd1,
    TL_GET         = 3'd4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    TL_ACCESS_ACK      = 3'd0,
    TL_ACCESS_ACK_DATA = 3'd1
  } tl_d_op_e;

  // a_size is log2 of the bus width in bytes
  function automatic logic [1:0] tlul_size_f(input int data_w);
    return 2'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/tlul_master_arbiter_if.sv
// Requester-side and TL-UL A/D bundle for tlul_master_arbiter; names are from the arbiter's view.
// master = arbiter, slave = the requesters plus the TL-UL interconnect.
interface tlul_master_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SRC_W   = 3
);
  logic [NUM_REQ-1:0]            i_req_valid;
  logic [NUM_REQ-1:0]            o_req_ready;
  logic [NUM_REQ-1:0]            i_req_write;
  logic [NUM_REQ*ADDR_W-1:0]     i_req_addr;
  logic [NUM_REQ*DATA_W-1:0]     i_req_wdata;
  logic [NUM_REQ*DATA_W/8-1:0]   i_req_mask;
  logic [NUM_REQ-1:0]            o_rsp_valid;
  logic [DATA_W-1:0]             o_rsp_rdata;
  logic                          o_rsp_error;

  logic                          o_a_valid;
  logic [2:0]                    o_a_opcode;
  logic [2:0]                    o_a_param;
  logic [1:0]                    o_a_size;
  logic [SRC_W-1:0]              o_a_source;
  logic [ADDR_W-1:0]             o_a_address;
  logic [DATA_W/8-1:0]           o_a_mask;
  logic [DATA_W-1:0]             o_a_data;
  logic                          i_a_ready;

  logic                          i_d_valid;
  logic [2:0]                    i_d_opcode;
  logic [SRC_W-1:0]              i_d_source;
  logic [DATA_W-1:0]             i_d_data;
  logic                          i_d_error;
  logic                          o_d_ready;
  logic                          o_err_unexp;

  modport master (
    input  i_req_valid, i_req_write, i_req_addr, i_req_wdata, i_req_mask,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_error,
    output o_a_valid, o_a_opcode, o_a_param, o_a_size, o_a_source, o_a_address, o_a_mask, o_a_data,
    input  i_a_ready,
    input  i_d_valid, i_d_opcode, i_d_source, i_d_data, i_d_error,
    output o_d_ready, o_err_unexp
  );

  modport slave (
    output i_req_valid, i_req_write, i_req_addr, i_req_wdata, i_req_mask,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_error,
    input  o_a_valid, o_a_opcode, o_a_param, o_a_size, o_a_source, o_a_address, o_a_mask, o_a_data,
    output i_a_ready,
    output i_d_valid, i_d_opcode, i_d_source, i_d_data, i_d_error,
    input  o_d_ready, o_err_unexp
  );
endinterface

// File: rtl/tlul_rr_arbiter.sv
// One-hot grant among req; round-robin pointer moves past the winner on advance.
// Defining TLUL_ARB_FIXED_PRIO_EN gives fixed priority (lowest index wins) with no pointer.
module tlul_rr_arbiter #(
  parameter int N = 2
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

`ifdef TLUL_ARB_FIXED_PRIO_EN
  assign gnt = req & (~req + N'(1));

  logic unused_arb;
  assign unused_arb = ^{i_clk, i_reset_n, advance};
`else
  localparam int PTR_W = $clog2(N);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [2*N-1:0]   dbl_req, dbl_gnt;
  logic [N-1:0]     rot_req, rot_gnt;

  // Rotate so the pointer position is bit 0, take the lowest set bit, rotate back.
  always_comb begin
    dbl_req = {req, req} >> ptr_q;
    rot_req = dbl_req[N-1:0];
    rot_gnt = rot_req & (~rot_req + N'(1));
    dbl_gnt = {rot_gnt, rot_gnt} << ptr_q;
    gnt     = dbl_gnt[2*N-1:N];
    ptr_d   = ptr_q;
    if (advance) begin
      for (int j = 0; j < N; j++) begin
        if (gnt[j]) ptr_d = (j == N - 1) ? '0 : PTR_W'(j + 1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) ptr_q <= '0;
    else            ptr_q <= ptr_d;
  end
`endif

endmodule

// File: rtl/tlul_master_arbiter.sv
// Shares one TL-UL master port among NUM_REQ requesters: registered A stage, one transaction per
// requester, D responses routed by d_source. Arbitration policy: TLUL_ARB_FIXED_PRIO_EN (tlul_rr_arbiter).
module tlul_master_arbiter
  import tlul_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SRC_W   = 3
) (
  input logic                  i_clk,
  input logic                  i_reset_n,
  tlul_master_arbiter_if.master bus
);

  localparam int         MASK_W = DATA_W / 8;
  localparam logic [1:0] A_SIZE = tlul_size_f(DATA_W);

  logic [NUM_REQ-1:0] pending_q, pending_d, stage_oh_q, stage_oh_d;
  logic [NUM_REQ-1:0] eligible, gnt, a_set, d_hit, d_ok_vec;
  logic               advance, a_fire, d_fire, d_ok;

  logic               a_valid_q, a_valid_d;
  logic [2:0]         a_opcode_q, a_opcode_d;
  logic [1:0]         a_size_q, a_size_d;
  logic [SRC_W-1:0]   a_source_q, a_source_d;
  logic [ADDR_W-1:0]  a_addr_q, a_addr_d;
  logic [MASK_W-1:0]  a_mask_q, a_mask_d;
  logic [DATA_W-1:0]  a_data_q, a_data_d;

  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               rsp_error_q, rsp_error_d;
  logic               d_ready_q, err_q, err_d;

  logic               sel_write;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic [MASK_W-1:0]  sel_mask;
  logic [SRC_W-1:0]   sel_src;

  // The requester sitting in the A stage is not yet pending, so it is blocked explicitly.
  assign a_fire   = a_valid_q && bus.i_a_ready;
  assign a_set    = a_fire ? stage_oh_q : '0;
  assign eligible = bus.i_req_valid & ~pending_q & ~(a_valid_q ? stage_oh_q : '0);
  assign advance  = i_reset_n && (!a_valid_q || bus.i_a_ready) && (|eligible);

  tlul_rr_arbiter #(.N(NUM_REQ)) u_arb (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .req       (eligible),
    .advance   (advance),
    .gnt       (gnt)
  );

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_mask  = '0;
    sel_src   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        sel_write = bus.i_req_write[k];
        sel_addr  = bus.i_req_addr[k*ADDR_W +: ADDR_W];
        sel_wdata = bus.i_req_wdata[k*DATA_W +: DATA_W];
        sel_mask  = bus.i_req_mask[k*MASK_W +: MASK_W];
        sel_src   = SRC_W'(k);
      end
    end
  end

  always_comb begin
    a_valid_d  = a_valid_q;
    a_opcode_d = a_opcode_q;
    a_size_d   = a_size_q;
    a_source_d = a_source_q;
    a_addr_d   = a_addr_q;
    a_mask_d   = a_mask_q;
    a_data_d   = a_data_q;
    stage_oh_d = stage_oh_q;
    if (advance) begin
      a_valid_d  = 1'b1;
      a_opcode_d = sel_write ? ((&sel_mask) ? TL_PUT_FULL : TL_PUT_PARTIAL) : TL_GET;
      a_size_d   = A_SIZE;
      a_source_d = sel_src;
      a_addr_d   = sel_addr;
      a_mask_d   = sel_mask;
      a_data_d   = sel_write ? sel_wdata : '0;
      stage_oh_d = gnt;
    end else if (a_fire) begin
      a_valid_d  = 1'b0;
    end
  end

  // A D beat colliding with an A handshake of the same source counts as unexpected.
  always_comb begin
    d_fire = bus.i_d_valid && d_ready_q;
    d_hit  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      d_hit[k] = d_fire && (bus.i_d_source == SRC_W'(k));
    end
    d_ok_vec    = d_hit & pending_q & ~a_set;
    d_ok        = |d_ok_vec;
    pending_d   = (pending_q | a_set) & ~d_ok_vec;
    rsp_valid_d = d_ok_vec;
    rsp_rdata_d = d_ok ? bus.i_d_data  : rsp_rdata_q;
    rsp_error_d = d_ok ? bus.i_d_error : rsp_error_q;
    err_d       = err_q | (d_fire && !d_ok);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      pending_q   <= '0;
      stage_oh_q  <= '0;
      a_valid_q   <= 1'b0;
      a_opcode_q  <= '0;
      a_size_q    <= '0;
      a_source_q  <= '0;
      a_addr_q    <= '0;
      a_mask_q    <= '0;
      a_data_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      d_ready_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      stage_oh_q  <= stage_oh_d;
      a_valid_q   <= a_valid_d;
      a_opcode_q  <= a_opcode_d;
      a_size_q    <= a_size_d;
      a_source_q  <= a_source_d;
      a_addr_q    <= a_addr_d;
      a_mask_q    <= a_mask_d;
      a_data_q    <= a_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      d_ready_q   <= 1'b1;
      err_q       <= err_d;
    end
  end

  assign bus.o_req_ready = advance ? gnt : '0;
  assign bus.o_a_valid   = a_valid_q;
  assign bus.o_a_opcode  = a_opcode_q;
  assign bus.o_a_param   = 3'd0;
  assign bus.o_a_size    = a_size_q;
  assign bus.o_a_source  = a_source_q;
  assign bus.o_a_address = a_addr_q;
  assign bus.o_a_mask    = a_mask_q;
  assign bus.o_a_data    = a_data_q;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_rdata = rsp_rdata_q;
  assign bus.o_rsp_error = rsp_error_q;
  assign bus.o_d_ready   = d_ready_q;
  assign bus.o_err_unexp = err_q;

  logic unused_d_op;
  assign unused_d_op = ^bus.i_d_opcode;

endmodule
